// File: rtl/mesh_router_xy_pkg.sv
// Shared types for the XY mesh router: packet/address layout, port indices, round-robin helper.
package mesh_router_xy_pkg;

  localparam int MESH_DIMENSION = 5;
  localparam int NUM_PORTS      = 5;
  localparam int COORD_W        = 4;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_EAST  = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } addr_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    addr_t       addr;
    logic [31:0] data;
  } pkt_t;

  // Next port index in the cyclic order 0..NUM_PORTS-1.
  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return (p == 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/mesh_router_xy_in_fifo.sv
// Per-input packet FIFO of the mesh router; full/empty derive from a registered occupancy count.
module router_in_fifo
  import mesh_router_xy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  pkt_t pkt,
  input  logic pop,
  output pkt_t head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its head downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= pkt;
  end

endmodule

// File: rtl/mesh_router_xy.sv
// 5-port XY dimension-order mesh router tile: input FIFOs, per-output round-robin, output register.
// Optional per-port forward / drop statistics under MESH_ROUTER_STATS_EN.
module mesh_router_xy
  import mesh_router_xy_pkg::*;
#(
  parameter int MESH_DIM   = MESH_DIMENSION,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  pkt_t [NUM_PORTS-1:0]          in_pkt,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output pkt_t [NUM_PORTS-1:0]          out_pkt,
`ifdef MESH_ROUTER_STATS_EN
  output logic [NUM_PORTS-1:0][15:0]    stat_fwd_cnt,
  output logic [7:0]                    stat_drop_cnt,
`endif
  output logic                          err_bad_addr
);

  localparam logic [COORD_W:0]   DIM_C = (COORD_W + 1)'(MESH_DIM);
  localparam logic [COORD_W-1:0] X_C   = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] Y_C   = COORD_W'(MY_Y);

  pkt_t [NUM_PORTS-1:0]      head;
  logic [NUM_PORTS-1:0]      empty, full, pop, bad;
  port_e                     route [NUM_PORTS];

  logic [NUM_PORTS-1:0]      out_valid_q, out_valid_d;
  pkt_t [NUM_PORTS-1:0]      out_pkt_q, out_pkt_d;
  logic [NUM_PORTS-1:0][2:0] rr_ptr_q, rr_ptr_d;
  logic                      err_q, err_d;

  logic                      found;
  logic [2:0]                win, idx;

  // Both handshakes transfer on a rising edge where valid && ready; valid/data hold until then.
  assign in_ready     = ~full;
  assign out_valid    = out_valid_q;
  assign out_pkt      = out_pkt_q;
  assign err_bad_addr = err_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    router_in_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[i] && in_ready[i]),
      .pkt   (in_pkt[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    bad = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = PORT_LOCAL;
      bad[i]   = !empty[i] && (({1'b0, head[i].addr.x} >= DIM_C) ||
                               ({1'b0, head[i].addr.y} >= DIM_C));
      if (head[i].addr.x > X_C)      route[i] = PORT_EAST;
      else if (head[i].addr.x < X_C) route[i] = PORT_WEST;
      else if (head[i].addr.y > Y_C) route[i] = PORT_NORTH;
      else if (head[i].addr.y < Y_C) route[i] = PORT_SOUTH;
      else                           route[i] = PORT_LOCAL;
    end
  end

  // Each head routes to exactly one output, so no input can be popped twice in a cycle.
  always_comb begin
    pop         = bad;
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    rr_ptr_d    = rr_ptr_q;
    err_d       = err_q | (|bad);
    found       = 1'b0;
    win         = '0;
    idx         = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found = 1'b0;
      win   = '0;
      idx   = rr_ptr_q[o];
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!found && !empty[idx] && !bad[idx] && (route[idx] == port_e'(o))) begin
          found = 1'b1;
          win   = idx;
        end
        idx = rr_next(idx);
      end
      if (!out_valid_q[o] || out_ready[o]) begin
        if (found) begin
          out_valid_d[o] = 1'b1;
          out_pkt_d[o]   = head[win];
          pop[win]       = 1'b1;
          rr_ptr_d[o]    = rr_next(win);
        end else begin
          out_valid_d[o] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_pkt_q   <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
    end
  end

`ifdef MESH_ROUTER_STATS_EN
  logic [NUM_PORTS-1:0][15:0] fwd_cnt_q, fwd_cnt_d;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;
  logic [2:0]                 drop_now;
  logic [8:0]                 drop_sum;

  assign stat_fwd_cnt  = fwd_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    drop_now  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_valid_q[o] && out_ready[o] && (fwd_cnt_q[o] != 16'hFFFF))
        fwd_cnt_d[o] = fwd_cnt_q[o] + 16'd1;
    end
    for (int i = 0; i < NUM_PORTS; i++) drop_now = drop_now + {2'b00, bad[i]};
    drop_sum   = {1'b0, drop_cnt_q} + {6'b0, drop_now};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy on tile (2,2): routing, arbitration, backpressure, bad address, reset.
module tb_mesh_router_xy;
  import mesh_router_xy_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [4:0]           in_valid;
  logic [4:0]           in_ready;
  pkt_t [4:0]           in_pkt;
  logic [4:0]           out_valid;
  logic [4:0]           out_ready;
  pkt_t [4:0]           out_pkt;
  logic                 err_bad_addr;

  int tests;
  int fails;

  mesh_router_xy #(
    .MESH_DIM   (5),
    .MY_X       (2),
    .MY_Y       (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pkt       (in_pkt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pkt      (out_pkt),
    .err_bad_addr (err_bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t mk_pkt(input int x, input int y, input int z, input logic [31:0] d);
    pkt_t p;
    p.ctrl   = 8'h5A ^ d[7:0];
    p.addr.x = COORD_W'(x);
    p.addr.y = COORD_W'(y);
    p.addr.z = COORD_W'(z);
    p.data   = d;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_pkt    = '0;
    out_ready = 5'h1F;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 5'h1F) begin fails++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 5'h1F); end
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 5'h00); end
    tests++; if (out_pkt !== '0) begin fails++; $display("FAIL reset_out_pkt got=%h exp=0", out_pkt); end
    tests++; if (err_bad_addr !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_bad_addr); end
    tests++; if (dut.rr_ptr_q !== 15'h0) begin fails++; $display("FAIL reset_rr got=%h exp=0", dut.rr_ptr_q); end
  endtask

  task automatic test_route();
    int   src   [5] = '{4, 0, 1, 3, 2};
    int   ax    [5] = '{4, 2, 2, 0, 2};
    int   ay    [5] = '{1, 0, 2, 3, 4};
    int   exp_o [5] = '{3, 2, 0, 4, 1};
    pkt_t p;
    logic [4:0] exp_v;
    for (int v = 0; v < 5; v++) begin
      p     = mk_pkt(ax[v], ay[v], 7, 32'hA000 + 32'(v));
      exp_v = 5'(1 << exp_o[v]);
      in_pkt[src[v]]   = p;
      in_valid[src[v]] = 1'b1;
      step();
      in_valid[src[v]] = 1'b0;
      tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL route_latency v=%0d got=%b exp=%b", v, out_valid, 5'h00); end
      step();
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL route_valid v=%0d got=%b exp=%b", v, out_valid, exp_v); end
      tests++; if (out_pkt[exp_o[v]] !== p) begin fails++; $display("FAIL route_pkt v=%0d got=%h exp=%h", v, out_pkt[exp_o[v]], p); end
      step();
    end
  endtask

  task automatic test_arbitration();
    int         srcs  [4] = '{0, 1, 2, 4};
    int         order [4] = '{0, 1, 2, 4};
    logic [2:0] exp_rr[4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic [31:0] exp_d;
    tests++; if (dut.rr_ptr_q[3] !== 3'd0) begin fails++; $display("FAIL arb_rr_start got=%0d exp=0", dut.rr_ptr_q[3]); end
    for (int s = 0; s < 4; s++) begin
      in_pkt[srcs[s]]   = mk_pkt(4, s, 3, 32'hC000 + 32'(srcs[s]));
      in_valid[srcs[s]] = 1'b1;
    end
    step();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_d = 32'hC000 + 32'(order[k]);
      tests++; if (out_valid[3] !== 1'b1) begin fails++; $display("FAIL arb_valid k=%0d got=%b exp=1", k, out_valid[3]); end
      tests++; if (out_pkt[3].data !== exp_d) begin fails++; $display("FAIL arb_order k=%0d got=%h exp=%h", k, out_pkt[3].data, exp_d); end
      tests++; if (dut.rr_ptr_q[3] !== exp_rr[k]) begin fails++; $display("FAIL arb_rr k=%0d got=%0d exp=%0d", k, dut.rr_ptr_q[3], exp_rr[k]); end
    end
    step();
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL arb_drain got=%b exp=%b", out_valid, 5'h00); end
  endtask

  task automatic test_backpressure();
    int          sent;
    logic        acc;
    logic [31:0] got_q[$];
    logic [31:0] exp_d;
    sent         = 0;
    out_ready[3] = 1'b0;
    in_pkt[4]    = mk_pkt(4, 2, 1, 32'hB000);
    in_valid[4]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = in_valid[4] && in_ready[4];
      step();
      if (acc) begin
        sent++;
        if (sent < 6) in_pkt[4] = mk_pkt(4, 2, 1, 32'hB000 + 32'(sent));
        else in_valid[4] = 1'b0;
      end
    end
    tests++; if (sent !== 5) begin fails++; $display("FAIL bp_accepts got=%0d exp=5", sent); end
    tests++; if (in_ready[4] !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b exp=0", in_ready[4]); end
    tests++; if (out_valid[3] !== 1'b1) begin fails++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid[3]); end
    tests++; if (out_pkt[3].data !== 32'hB000) begin fails++; $display("FAIL bp_hold_pkt got=%h exp=%h", out_pkt[3].data, 32'hB000); end
    out_ready[3] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid[3] && out_ready[3]) got_q.push_back(out_pkt[3].data);
      acc = in_valid[4] && in_ready[4];
      step();
      if (acc) begin
        sent++;
        if (sent < 6) in_pkt[4] = mk_pkt(4, 2, 1, 32'hB000 + 32'(sent));
        else in_valid[4] = 1'b0;
      end
    end
    tests++; if (sent !== 6) begin fails++; $display("FAIL bp_total_accepts got=%0d exp=6", sent); end
    tests++; if (got_q.size() !== 6) begin fails++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_d = 32'hB000 + 32'(i);
      if (i < got_q.size()) begin
        tests++; if (got_q[i] !== exp_d) begin fails++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got_q[i], exp_d); end
      end
    end
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL bp_drain got=%b exp=%b", out_valid, 5'h00); end
  endtask

  task automatic test_bad_addr();
    pkt_t good;
    good = mk_pkt(2, 0, 5, 32'hD001);
    tests++; if (err_bad_addr !== 1'b0) begin fails++; $display("FAIL bad_err_pre got=%b exp=0", err_bad_addr); end
    in_pkt[0]   = mk_pkt(5, 0, 0, 32'hD000);
    in_valid[0] = 1'b1;
    step();
    in_pkt[0] = good;
    step();
    in_valid[0] = 1'b0;
    tests++; if (err_bad_addr !== 1'b1) begin fails++; $display("FAIL bad_err_set got=%b exp=1", err_bad_addr); end
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL bad_dropped got=%b exp=%b", out_valid, 5'h00); end
    step();
    tests++; if (out_valid !== 5'b00100) begin fails++; $display("FAIL bad_follow_valid got=%b exp=%b", out_valid, 5'b00100); end
    tests++; if (out_pkt[2] !== good) begin fails++; $display("FAIL bad_follow_pkt got=%h exp=%h", out_pkt[2], good); end
    step();
    tests++; if (err_bad_addr !== 1'b1) begin fails++; $display("FAIL bad_err_sticky got=%b exp=1", err_bad_addr); end
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL bad_drain got=%b exp=%b", out_valid, 5'h00); end
  endtask

  task automatic test_reset_mid();
    out_ready = 5'h00;
    for (int s = 0; s < 3; s++) begin
      in_pkt[s]   = mk_pkt(4, 1, 2, 32'hE000 + 32'(s));
      in_valid[s] = 1'b1;
    end
    step();
    in_valid = '0;
    step();
    tests++; if (out_valid[3] !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid[3]); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL rst_async_valid got=%b exp=%b", out_valid, 5'h00); end
    tests++; if (out_pkt !== '0) begin fails++; $display("FAIL rst_async_pkt got=%h exp=0", out_pkt); end
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 5'h1F;
    tests++; if (in_ready !== 5'h1F) begin fails++; $display("FAIL rst_in_ready got=%b exp=%b", in_ready, 5'h1F); end
    tests++; if (err_bad_addr !== 1'b0) begin fails++; $display("FAIL rst_err_clear got=%b exp=0", err_bad_addr); end
    for (int c = 0; c < 6; c++) begin
      step();
      tests++; if (out_valid !== 5'h00) begin fails++; $display("FAIL rst_stale c=%0d got=%b exp=%b", c, out_valid, 5'h00); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_route();
    test_arbitration();
    test_backpressure();
    test_bad_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
